cpu_sequencer: RTL and testbench
================================

Name: cpu_sequencer

Overview:
- Multi-cycle control FSM for the 16-bit CPU datapath: owns the program counter and sequences FETCH/DECODE/EXEC/MEM/WB for each instruction.
- Sits between the combinational imem/control/ALU/regfile and replaces the free-running PC increment.
- Adds branch/jump resolution, a data-memory ready handshake with timeout, halt, and a retired-instruction counter.

Parameters:
- PC_RESET, 16'h0000, PC value loaded on reset.
- MEM_TIMEOUT, 8, max cycles in MEM waiting for mem_ready before fault (range 1..255).
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- run  in  1  start request, sampled in IDLE.
- instr  in  16  current instruction from imem (combinational on pc).
- is_zero  in  1  ALU zero flag, valid in EXEC.
- mem_ready  in  1  data memory completion, valid while mem_req=1.
- pc  out  16  program counter to imem.
- ir_load  out  1  one-cycle pulse in FETCH: latch instr.
- rf_we  out  1  one-cycle regfile write enable in WB.
- mem_req  out  1  held high in MEM until mem_ready or timeout.
- mem_we  out  1  equals mem_req for SW, else 0.
- state  out  3  current FSM state encoding (debug).
- halted  out  1  high in HALT.
- fault  out  1  sticky; set on memory timeout or reserved opcode.
- retired  out  CNT_W  count of completed instructions, wraps at 2^CNT_W.

Behaviour:
- Single clock domain; clk is the only clock. Reset is synchronous, active-high, named rst.
- Reset values: pc=PC_RESET, state=IDLE, ir_load=rf_we=mem_req=mem_we=0, halted=0, fault=0, retired=0. rst overrides everything, including mid-MEM; mem_req drops on the next edge.
- Opcode field is instr[15:13]. R=000, ADDI=001, LW=010, SW=011, BEQ=100, J=101, RSV=110, HALT=111.
- States and transitions:
  - IDLE: leave on run=1 to FETCH; otherwise stay. run is ignored in every other state.
  - FETCH (1 cycle): ir_load=1; go to DECODE.
  - DECODE (1 cycle): HALT goes to HALT; RSV goes to HALT with fault=1; all others go to EXEC.
  - EXEC (1 cycle): resolve next PC and register it into pc on exit. R/ADDI go to WB; LW/SW go to MEM; BEQ/J go to FETCH.
  - MEM: mem_req=1 each cycle. On mem_ready=1, LW goes to WB and SW goes to FETCH. mem_ready in the first MEM cycle gives a 1-cycle MEM. If MEM_TIMEOUT cycles elapse with no ready, go to HALT with fault=1 and do not retire.
  - WB (1 cycle): rf_we=1; go to FETCH.
  - HALT: absorbing until rst. pc is frozen.
- Next PC, all arithmetic mod 2^16:
  - Default: pc+1.
  - BEQ with is_zero=1: pc+1+sext(instr[6:0]).
  - J: pc+1+sext(instr[12:0]).
  - BEQ with is_zero=0: pc+1.
- Latency per instruction (cycles, FETCH to next FETCH): R/ADDI 4, BEQ/J 3, SW 3+m, LW 4+m, where m = MEM cycles (≥1).
- retired increments by 1 on the final cycle of each completed instruction (WB; EXEC for BEQ/J; MEM-with-ready for SW). HALT also retires, in DECODE. The counter wraps silently.
- pc wrap: 16'hFFFF+1 gives 16'h0000, with no flag.

Decomposition:
- Package cpu_pkg: opcode localparams (OP_R..OP_HALT), state enum typedef (IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT), and a sext helper function.
- Sub-module pc_next_unit: combinational target computation (pc, instr, is_zero, opcode -> next pc). The FSM, timeout counter and retire counter stay in cpu_sequencer.

Test Plan:
- Reset then run=1, with imem holding R,R,HALT at 0..2 -> pc 0,1,2. rf_we pulses exactly twice. halted=1 at cycle 10 after run. retired=3.
- BEQ imm=7'h7E (-2) at pc=5, is_zero=1 -> pc=4. Same with is_zero=0 -> pc=6. Each takes 3 cycles.
- J imm13=13'h1FFF at pc=0 -> pc=0 (0+1-1). J at pc=16'hFFFE with imm13=1 -> pc=16'h0000 (wrap).
- LW with mem_ready asserted 3 cycles after MEM entry -> mem_req high 3 cycles, then rf_we 1 cycle. Total 7 cycles. SW -> mem_we=mem_req, no rf_we.
- SW with mem_ready stuck 0, MEM_TIMEOUT=8 -> mem_req high exactly 8 cycles, then halted=1, fault=1, retired unchanged.
- rst asserted during MEM with mem_req=1 -> next edge: mem_req=0, state=IDLE, pc=PC_RESET, fault=0. run then restarts from PC_RESET.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared opcode values, sequencer state encoding and sign-extension helper.
package cpu_pkg;

    localparam logic [2:0] OP_R    = 3'd0;
    localparam logic [2:0] OP_ADDI = 3'd1;
    localparam logic [2:0] OP_LW   = 3'd2;
    localparam logic [2:0] OP_SW   = 3'd3;
    localparam logic [2:0] OP_BEQ  = 3'd4;
    localparam logic [2:0] OP_J    = 3'd5;
    localparam logic [2:0] OP_RSV  = 3'd6;
    localparam logic [2:0] OP_HALT = 3'd7;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5,
        HALT   = 3'd6
    } state_t;

    // Sign-extend the low 'bits' bits of v to 16 bits.
    function automatic logic [15:0] sext(input logic [15:0] v, input int unsigned bits);
        logic signed [15:0] t;
        t = $signed(v << (16 - bits));
        return $unsigned(t >>> (16 - bits));
    endfunction

endpackage

// File: rtl/cpu_sequencer_pc_next.sv
// Combinational next-PC resolution for branches and jumps.
module pc_next_unit
    import cpu_pkg::*;
(
    input  logic [15:0] pc,
    input  logic [15:0] instr,
    input  logic        is_zero,
    output logic [15:0] next_pc
);

    logic [15:0] seq_pc;

    assign seq_pc = pc + 16'd1;

    // Sequential PC unless a taken BEQ or a J redirects relative to pc+1.
    always_comb begin
        next_pc = seq_pc;
        case (instr[15:13])
            OP_BEQ:  if (is_zero) next_pc = seq_pc + sext(instr, 7);
            OP_J:    next_pc = seq_pc + sext(instr, 13);
            default: next_pc = seq_pc;
        endcase
    end

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer owning the program counter.
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter logic [15:0] PC_RESET    = 16'h0000,
    parameter int unsigned MEM_TIMEOUT = 8,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic [15:0]      instr,
    input  logic             is_zero,
    input  logic             mem_ready,
    output logic [15:0]      pc,
    output logic             ir_load,
    output logic             rf_we,
    output logic             mem_req,
    output logic             mem_we,
    output logic [2:0]       state,
    output logic             halted,
    output logic             fault,
    output logic [CNT_W-1:0] retired
);

    state_t      state_q;
    logic [15:0] ir;
    logic [7:0]  mem_cnt;
    logic [15:0] next_pc;
    logic [2:0]  op;

    // pc moves during EXEC, so the opcode must come from the copy taken in FETCH.
    assign op    = ir[15:13];
    assign state = state_q;

    pc_next_unit u_pc_next (
        .pc      (pc),
        .instr   (ir),
        .is_zero (is_zero),
        .next_pc (next_pc)
    );

    // Sequencer FSM; every output is registered on entry to the state it belongs to.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pc      <= PC_RESET;
            ir      <= '0;
            mem_cnt <= '0;
            ir_load <= 1'b0;
            rf_we   <= 1'b0;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            halted  <= 1'b0;
            fault   <= 1'b0;
            retired <= '0;
        end else begin
            ir_load <= 1'b0;
            rf_we   <= 1'b0;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (run) begin
                        state_q <= FETCH;
                        ir_load <= 1'b1;
                    end
                end
                FETCH: begin
                    ir      <= instr;
                    state_q <= DECODE;
                end
                DECODE: begin
                    case (op)
                        OP_HALT: begin
                            state_q <= HALT;
                            halted  <= 1'b1;
                            retired <= retired + 1'b1;
                        end
                        OP_RSV: begin
                            state_q <= HALT;
                            halted  <= 1'b1;
                            fault   <= 1'b1;
                        end
                        default: state_q <= EXEC;
                    endcase
                end
                EXEC: begin
                    pc <= next_pc;
                    case (op)
                        OP_R, OP_ADDI: begin
                            state_q <= WB;
                            rf_we   <= 1'b1;
                        end
                        OP_LW, OP_SW: begin
                            state_q <= MEM;
                            mem_req <= 1'b1;
                            mem_we  <= (op == OP_SW);
                            mem_cnt <= 8'd1;
                        end
                        default: begin
                            state_q <= FETCH;
                            ir_load <= 1'b1;
                            retired <= retired + 1'b1;
                        end
                    endcase
                end
                MEM: begin
                    if (mem_ready) begin
                        if (op == OP_LW) begin
                            state_q <= WB;
                            rf_we   <= 1'b1;
                        end else begin
                            state_q <= FETCH;
                            ir_load <= 1'b1;
                            retired <= retired + 1'b1;
                        end
                    end else if (mem_cnt == 8'(MEM_TIMEOUT)) begin
                        state_q <= HALT;
                        halted  <= 1'b1;
                        fault   <= 1'b1;
                    end else begin
                        mem_cnt <= mem_cnt + 8'd1;
                        mem_req <= 1'b1;
                        mem_we  <= (op == OP_SW);
                    end
                end
                WB: begin
                    state_q <= FETCH;
                    ir_load <= 1'b1;
                    retired <= retired + 1'b1;
                end
                HALT: state_q <= HALT;
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Randomized and directed checks of cpu_sequencer against an instruction-level model.
module tb_cpu_sequencer;
    import cpu_pkg::*;

    localparam int unsigned T = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        run = 1'b0;
    logic        is_zero = 1'b0;
    logic        mem_ready = 1'b0;
    logic [15:0] instr;
    logic [15:0] pc;
    logic        ir_load, rf_we, mem_req, mem_we, halted, fault;
    logic [2:0]  state;
    logic [15:0] retired;

    logic [15:0] imem [256];
    assign instr = imem[pc[7:0]];

    cpu_sequencer #(
        .PC_RESET    (16'h0000),
        .MEM_TIMEOUT (T),
        .CNT_W       (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .instr     (instr),
        .is_zero   (is_zero),
        .mem_ready (mem_ready),
        .pc        (pc),
        .ir_load   (ir_load),
        .rf_we     (rf_we),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .state     (state),
        .halted    (halted),
        .fault     (fault),
        .retired   (retired)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Memory model: answers on the mem_delay-th cycle of a request; 0 never answers.
    int mem_delay = 1;
    int mcnt = 0;
    always @(negedge clk) begin
        if (mem_req) begin
            mcnt++;
            mem_ready = (mem_delay != 0) && (mcnt == mem_delay);
        end else begin
            mcnt = 0;
            mem_ready = 1'b0;
        end
    end

    // Reference model state
    logic [15:0] m_pc;
    logic [15:0] m_ret;
    bit          m_halt;
    bit          m_fault;
    int          total_cyc;
    int          total_rf;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] enc(input int op, input int imm);
        logic [15:0] w;
        w = 16'(imm);
        w[15:13] = 3'(op);
        return w;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        run = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_eq("rst_pc", pc, 16'h0000);
        check_eq("rst_state", state, 32'(IDLE));
        check_eq("rst_strobes", {ir_load, rf_we, mem_req, mem_we}, 0);
        check_eq("rst_flags", {halted, fault}, 0);
        check_eq("rst_retired", retired, 0);
        m_pc = 16'h0000; m_ret = '0; m_halt = 0; m_fault = 0;
        total_cyc = 0; total_rf = 0;
    endtask

    task automatic start();
        run = 1'b1;
        @(posedge clk);
        #1;
        run = 1'b0;
        check_eq("start_ir_load", ir_load, 1);
    endtask

    // Called while the DUT sits in FETCH; runs one instruction to the next FETCH or HALT.
    task automatic run_one(input bit z, input int d);
        logic [15:0] ins, npc;
        int op, e_cyc, e_rf, e_mrq, e_mwe, cyc, rfc, mrq, mwe;
        bit e_halt, e_fault, ret_inc;
        check_eq("fetch_pc", pc, m_pc);
        ins = imem[m_pc[7:0]];
        is_zero = z;
        mem_delay = d;
        op = int'(ins[15:13]);
        npc = m_pc + 16'd1;
        e_rf = 0; e_mrq = 0; e_mwe = 0; e_halt = 0; e_fault = 0; ret_inc = 0; e_cyc = 0;
        case (op)
            0, 1: begin e_cyc = 4; e_rf = 1; ret_inc = 1; end
            2, 3: begin
                if (d == 0 || d > int'(T)) begin
                    e_cyc = 3 + int'(T); e_mrq = int'(T); e_halt = 1; e_fault = 1;
                end else begin
                    e_mrq = d;
                    e_cyc = (op == 2) ? 4 + d : 3 + d;
                    e_rf = (op == 2) ? 1 : 0;
                    ret_inc = 1;
                end
                e_mwe = (op == 3) ? e_mrq : 0;
            end
            4: begin
                if (z) npc = m_pc + 16'd1 + {{9{ins[6]}}, ins[6:0]};
                e_cyc = 3; ret_inc = 1;
            end
            5: begin
                npc = m_pc + 16'd1 + {{3{ins[12]}}, ins[12:0]};
                e_cyc = 3; ret_inc = 1;
            end
            6: begin e_cyc = 2; npc = m_pc; e_halt = 1; e_fault = 1; end
            default: begin e_cyc = 2; npc = m_pc; e_halt = 1; ret_inc = 1; end
        endcase

        cyc = 0; rfc = 0; mrq = 0; mwe = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            cyc++;
            if (ir_load || halted) break;
            rfc += int'(rf_we);
            mrq += int'(mem_req);
            mwe += int'(mem_we);
        end

        m_pc = npc;
        if (ret_inc) m_ret = m_ret + 16'd1;
        m_halt = e_halt;
        if (e_fault) m_fault = 1;
        total_cyc += cyc;
        total_rf += rfc;

        check_eq("cycles", cyc, e_cyc);
        check_eq("rf_we_count", rfc, e_rf);
        check_eq("mem_req_count", mrq, e_mrq);
        check_eq("mem_we_count", mwe, e_mwe);
        check_eq("next_pc", pc, m_pc);
        check_eq("retired", retired, m_ret);
        check_eq("halted", halted, m_halt);
        check_eq("fault", fault, m_fault);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) imem[i] = 16'h0000;

        // R, R, HALT
        imem[0] = enc(0, 0); imem[1] = enc(0, 0); imem[2] = enc(7, 0);
        do_reset();
        start();
        run_one(0, 1); run_one(0, 1); run_one(0, 1);
        check_eq("rrh_halt_cycle", total_cyc, 10);
        check_eq("rrh_rf_pulses", total_rf, 2);
        check_eq("rrh_retired", retired, 3);

        // BEQ taken/not taken at pc 5, reached by J
        imem[0] = enc(5, 4); imem[5] = enc(4, 7'h7E); imem[4] = enc(5, 0);
        do_reset();
        start();
        run_one(0, 1); run_one(1, 1); run_one(0, 1); run_one(0, 1);

        // J to self-minus-one and wrap through 0xFFFE
        imem[0] = enc(5, 13'h1FFD); imem[8'hFE] = enc(5, 1);
        do_reset();
        start();
        run_one(0, 1); run_one(0, 1);
        imem[0] = enc(5, 13'h1FFF);
        do_reset();
        start();
        run_one(0, 1);

        // LW ready on 3rd MEM cycle, SW, then SW timeout
        imem[0] = enc(2, 0); imem[1] = enc(3, 0); imem[2] = enc(3, 0);
        do_reset();
        start();
        run_one(0, 3); run_one(0, 2); run_one(0, 0);

        // Reserved opcode
        imem[0] = enc(6, 0);
        do_reset();
        start();
        run_one(0, 1);

        // Reset while a request is outstanding
        imem[0] = enc(2, 0);
        do_reset();
        mem_delay = 0;
        start();
        for (int k = 0; k < 10; k++) begin
            if (mem_req) break;
            @(posedge clk);
            #1;
        end
        check_eq("midmem_req_seen", mem_req, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_eq("midmem_req_drop", mem_req, 0);
        check_eq("midmem_state", state, 32'(IDLE));
        check_eq("midmem_pc", pc, 16'h0000);
        check_eq("midmem_fault", fault, 0);
        do_reset();
        start();
        run_one(0, 1);

        // Random program
        for (int i = 0; i < 256; i++) begin
            int r;
            int opr;
            r = int'($urandom_range(0, 19));
            opr = (r < 4) ? 0 : (r < 7) ? 1 : (r < 10) ? 2 : (r < 13) ? 3 :
                  (r < 16) ? 4 : (r < 19) ? 5 : 7;
            imem[i] = enc(opr, int'($urandom_range(0, 8191)));
        end
        do_reset();
        start();
        for (int n = 0; n < 200; n++) begin
            int d;
            d = ($urandom_range(0, 29) == 0) ? 0 : int'($urandom_range(1, 4));
            run_one(1'($urandom_range(0, 1)), d);
            if (m_halt) begin
                do_reset();
                start();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1);
    end

endmodule
